// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC -> memory request -> IR with valid/accept
// One outstanding request at a time; flushed requests are drained before returning to IDLE.
module fetch_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              Flush,
  input  logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemData,
  input  logic              MemReady,
  output logic              IncrPc,
  output logic [DATA_W-1:0] IR,
  output logic              IRValid,
  input  logic              IRAccept,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             expired;

  // Saturating so a disabled or long timeout can never wrap back to zero.
  assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
  assign expired   = (TIMEOUT != 0) && (count_inc >= CNT_TO);
  assign Busy      = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      count   <= '0;
      MemAddr <= '0;
      MemRead <= 1'b0;
      IncrPc  <= 1'b0;
      IR      <= '0;
      IRValid <= 1'b0;
      Err     <= 1'b0;
    end else begin
      IncrPc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Run && !Flush) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (Flush) begin
            state <= S_IDLE;
          end else begin
            MemAddr <= PC;
            MemRead <= 1'b1;
            count   <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (MemReady) begin
            MemRead <= 1'b0;
            if (Flush) begin
              state <= S_IDLE;
            end else begin
              IR      <= MemData;
              IRValid <= 1'b1;
              IncrPc  <= 1'b1;
              state   <= S_HOLD;
            end
          end else begin
            // A timeout ends the fetch outright, whether or not a flush is pending.
            count <= count_inc;
            if (expired) begin
              Err     <= 1'b1;
              MemRead <= 1'b0;
              state   <= S_IDLE;
            end else if (Flush) begin
              MemRead <= 1'b0;
              state   <= S_DRAIN;
            end
          end
        end
        S_HOLD: begin
          if (Flush) begin
            IRValid <= 1'b0;
            state   <= S_IDLE;
          end else if (IRAccept) begin
            IRValid <= 1'b0;
            state   <= Run ? S_ISSUE : S_IDLE;
          end
        end
        S_DRAIN: begin
          // The counter keeps running from WAIT: the bound covers the whole request.
          if (MemReady) begin
            state <= S_IDLE;
          end else begin
            count <= count_inc;
            if (expired) begin
              Err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
